// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and FSM state encoding for the instruction-fetch controller.
package inst_fetch_ctrl_pkg;

  localparam logic        RST_ENABLE     = 1'b0;
  localparam logic [31:0] ZEROWORD32     = 32'h0000_0000;
  localparam int unsigned EXCEP_ADEL_BIT = 31;

  typedef enum logic [1:0] {
    IFC_IDLE = 2'd0,
    IFC_REQ  = 2'd1,
    IFC_WAIT = 2'd2,
    IFC_HOLD = 2'd3
  } ifc_state_t;

endpackage

// File: rtl/inst_fetch_ctrl_redirect_q.sv
// Pending exception/branch redirect registers and the next-fetch-PC mux.
module ifc_redirect_q
  import inst_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_i,
  input  logic [31:0] exception_pc_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_addr_i,
  input  logic        take_i,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o
);

  logic        exc_pend;
  logic [31:0] exc_pc;
  logic        br_pend;
  logic [31:0] br_pc;

  // Live pulses are folded in so a redirect arriving on the take cycle is not missed.
  always_comb begin
    next_pc_o = pc_i + 32'd4;
    if (exception_i)          next_pc_o = exception_pc_i;
    else if (exc_pend)        next_pc_o = exc_pc;
    else if (branch_enable_i) next_pc_o = branch_addr_i;
    else if (br_pend)         next_pc_o = br_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      exc_pend <= 1'b0;
      exc_pc   <= ZEROWORD32;
      br_pend  <= 1'b0;
      br_pc    <= ZEROWORD32;
    end else if (exception_i) begin
      exc_pend <= !take_i;
      exc_pc   <= exception_pc_i;
      br_pend  <= 1'b0;
    end else begin
      if (take_i && exc_pend)
        exc_pend <= 1'b0;
      if (branch_enable_i) begin
        br_pc   <= branch_addr_i;
        br_pend <= !(take_i && !exc_pend);
      end else if (take_i && !exc_pend && br_pend) begin
        br_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the SRAM-like bus, hands payload to IF/ID.
// Optional misaligned-fetch (AdEL) detection is enabled by defining FETCH_ADEL_CHECK_EN.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int unsigned EXCEP_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         stall_i,
  input  logic               exception_i,
  input  logic [31:0]        exception_pc_i,
  input  logic               branch_enable_i,
  input  logic [31:0]        branch_addr_i,
  output logic               inst_req_o,
  output logic [31:0]        inst_addr_o,
  input  logic               inst_addr_ok_i,
  input  logic               inst_data_ok_i,
  input  logic [31:0]        inst_rdata_i,
  output logic               if_valid_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_inst_o,
  output logic [EXCEP_W-1:0] if_exception_type_o,
  output logic               inst_stall_o
);

  ifc_state_t state, state_nx;
  logic [31:0] pc, next_pc;
  logic        discard, discard_nx;
  logic        take, deliver, buffer, emit_hold;
  logic        stalled, adel;
  logic [31:0]        fetch_inst;
  logic [EXCEP_W-1:0] fetch_exc;
  logic [31:0]        hold_pc, hold_inst;
  logic [EXCEP_W-1:0] hold_exc;

  assign stalled = |stall_i;

`ifdef FETCH_ADEL_CHECK_EN
  assign adel = (state == IFC_REQ) && (pc[1:0] != 2'b00);
`else
  assign adel = 1'b0;
`endif

  assign fetch_inst = adel ? ZEROWORD32 : inst_rdata_i;

  always_comb begin
    fetch_exc = '0;
    fetch_exc[EXCEP_ADEL_BIT] = adel;
  end

  assign inst_req_o   = (state == IFC_REQ) && !adel;
  assign inst_addr_o  = pc;
  assign inst_stall_o = (state == IFC_REQ) || (state == IFC_WAIT);

  ifc_redirect_q u_redirect (
    .clk             (clk),
    .rst             (rst),
    .exception_i     (exception_i),
    .exception_pc_i  (exception_pc_i),
    .branch_enable_i (branch_enable_i),
    .branch_addr_i   (branch_addr_i),
    .take_i          (take),
    .pc_i            (pc),
    .next_pc_o       (next_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) state <= IFC_IDLE;
    else                   state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    discard_nx = discard;
    take       = 1'b0;
    deliver    = 1'b0;
    buffer     = 1'b0;
    emit_hold  = 1'b0;
    case (state)
      IFC_IDLE: state_nx = IFC_REQ;
      IFC_REQ: begin
        // A faulting fetch skips the bus and behaves like an immediate data_ok.
        if (adel) begin
          if (exception_i) begin
            take = 1'b1;
          end else if (stalled) begin
            buffer   = 1'b1;
            state_nx = IFC_HOLD;
          end else begin
            deliver = 1'b1;
            take    = 1'b1;
          end
        end else begin
          if (exception_i)    discard_nx = 1'b1;
          if (inst_addr_ok_i) state_nx   = IFC_WAIT;
        end
      end
      IFC_WAIT: begin
        if (inst_data_ok_i) begin
          if (discard || exception_i) begin
            discard_nx = 1'b0;
            take       = 1'b1;
            state_nx   = IFC_REQ;
          end else if (stalled) begin
            buffer   = 1'b1;
            state_nx = IFC_HOLD;
          end else begin
            deliver  = 1'b1;
            take     = 1'b1;
            state_nx = IFC_REQ;
          end
        end else if (exception_i) begin
          discard_nx = 1'b1;
        end
      end
      IFC_HOLD: begin
        if (exception_i) begin
          take     = 1'b1;
          state_nx = IFC_REQ;
        end else if (!stalled) begin
          emit_hold = 1'b1;
          take      = 1'b1;
          state_nx  = IFC_REQ;
        end
      end
      default: state_nx = IFC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      discard <= discard_nx;
      if (take) pc <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      if_valid_o          <= 1'b0;
      if_pc_o             <= ZEROWORD32;
      if_inst_o           <= ZEROWORD32;
      if_exception_type_o <= '0;
      hold_pc             <= ZEROWORD32;
      hold_inst           <= ZEROWORD32;
      hold_exc            <= '0;
    end else begin
      if_valid_o <= deliver | emit_hold;
      if (deliver) begin
        if_pc_o             <= pc;
        if_inst_o           <= fetch_inst;
        if_exception_type_o <= fetch_exc;
      end else if (emit_hold) begin
        if_pc_o             <= hold_pc;
        if_inst_o           <= hold_inst;
        if_exception_type_o <= hold_exc;
      end
      if (buffer) begin
        hold_pc   <= pc;
        hold_inst <= fetch_inst;
        hold_exc  <= fetch_exc;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl; define FETCH_ADEL_CHECK_EN to cover AdEL.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  stall_i;
  logic        exception_i;
  logic [31:0] exception_pc_i;
  logic        branch_enable_i;
  logic [31:0] branch_addr_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_exception_type_o;
  logic        inst_stall_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  inst_fetch_ctrl #(
    .RESET_PC (32'hbfc0_0000),
    .EXCEP_W  (32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_i             (stall_i),
    .exception_i         (exception_i),
    .exception_pc_i      (exception_pc_i),
    .branch_enable_i     (branch_enable_i),
    .branch_addr_i       (branch_addr_i),
    .inst_req_o          (inst_req_o),
    .inst_addr_o         (inst_addr_o),
    .inst_addr_ok_i      (inst_addr_ok_i),
    .inst_data_ok_i      (inst_data_ok_i),
    .inst_rdata_i        (inst_rdata_i),
    .if_valid_o          (if_valid_o),
    .if_pc_o             (if_pc_o),
    .if_inst_o           (if_inst_o),
    .if_exception_type_o (if_exception_type_o),
    .inst_stall_o        (inst_stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts and ends at a negedge with the DUT in REQ.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic br, input logic [31:0] br_addr);
    check_val({tag, ".req"},   32'(inst_req_o), 32'd1);
    check_val({tag, ".addr"},  inst_addr_o, addr);
    check_val({tag, ".stall"}, 32'(inst_stall_o), 32'd1);
    inst_addr_ok_i  = 1'b1;
    branch_enable_i = br;
    branch_addr_i   = br_addr;
    cyc();
    inst_addr_ok_i  = 1'b0;
    branch_enable_i = 1'b0;
    check_val({tag, ".wait_req"},   32'(inst_req_o), 32'd0);
    check_val({tag, ".wait_valid"}, 32'(if_valid_o), 32'd0);
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = data;
    cyc();
    inst_data_ok_i = 1'b0;
    check_val({tag, ".valid"}, 32'(if_valid_o), 32'd1);
    check_val({tag, ".pc"},    if_pc_o, addr);
    check_val({tag, ".inst"},  if_inst_o, data);
    check_val({tag, ".excep"}, if_exception_type_o, 32'd0);
  endtask

  initial begin
    stall_i         = 4'b0000;
    exception_i     = 1'b0;
    exception_pc_i  = 32'h0;
    branch_enable_i = 1'b0;
    branch_addr_i   = 32'h0;
    inst_addr_ok_i  = 1'b0;
    inst_data_ok_i  = 1'b0;
    inst_rdata_i    = 32'h0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    check_val("rst.req",   32'(inst_req_o), 32'd0);
    check_val("rst.addr",  inst_addr_o, 32'hbfc0_0000);
    check_val("rst.valid", 32'(if_valid_o), 32'd0);
    check_val("rst.pc",    if_pc_o, 32'd0);
    check_val("rst.inst",  if_inst_o, 32'd0);
    check_val("rst.excep", if_exception_type_o, 32'd0);
    check_val("rst.stall", 32'(inst_stall_o), 32'd0);

    rst = 1'b1;
    cyc();

    // Sequential fetch
    do_fetch("seq0", 32'hbfc0_0000, 32'h1111_0000, 1'b0, 32'h0);
    do_fetch("seq1", 32'hbfc0_0004, 32'h1111_0004, 1'b0, 32'h0);

    // Branch during delay-slot fetch
    do_fetch("br", 32'hbfc0_0008, 32'h2222_0008, 1'b1, 32'hbfc0_0100);

    // Stall around data_ok -> HOLD
    check_val("hold.addr", inst_addr_o, 32'hbfc0_0100);
    inst_addr_ok_i = 1'b1;
    cyc();
    inst_addr_ok_i = 1'b0;
    stall_i        = 4'b0100;
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = 32'h3333_0100;
    cyc();
    inst_data_ok_i = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      check_val("hold.valid", 32'(if_valid_o), 32'd0);
      check_val("hold.req",   32'(inst_req_o), 32'd0);
      check_val("hold.stall", 32'(inst_stall_o), 32'd0);
      cyc();
    end
    check_val("hold.valid2", 32'(if_valid_o), 32'd0);
    stall_i = 4'b0000;
    cyc();
    check_val("rel.valid", 32'(if_valid_o), 32'd1);
    check_val("rel.pc",    if_pc_o, 32'hbfc0_0100);
    check_val("rel.inst",  if_inst_o, 32'h3333_0100);
    check_val("rel.addr",  inst_addr_o, 32'hbfc0_0104);
    cyc();
    check_val("rel.once",  32'(if_valid_o), 32'd0);

    // Exception in WAIT with simultaneous branch
    check_val("exw.addr", inst_addr_o, 32'hbfc0_0104);
    inst_addr_ok_i = 1'b1;
    cyc();
    inst_addr_ok_i  = 1'b0;
    exception_i     = 1'b1;
    exception_pc_i  = 32'hbfc0_0380;
    branch_enable_i = 1'b1;
    branch_addr_i   = 32'hbfc0_0200;
    cyc();
    exception_i     = 1'b0;
    branch_enable_i = 1'b0;
    inst_data_ok_i  = 1'b1;
    inst_rdata_i    = 32'h4444_0104;
    cyc();
    inst_data_ok_i = 1'b0;
    check_val("exw.valid", 32'(if_valid_o), 32'd0);
    do_fetch("exw.tgt", 32'hbfc0_0380, 32'h5555_0380, 1'b0, 32'h0);

    // Exception in REQ with addr_ok delayed
    exception_i    = 1'b1;
    exception_pc_i = 32'hbfc0_0500;
    cyc();
    exception_i = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      check_val("exr.req",  32'(inst_req_o), 32'd1);
      check_val("exr.addr", inst_addr_o, 32'hbfc0_0384);
      if (i < 3) cyc();
    end
    inst_addr_ok_i = 1'b1;
    cyc();
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = 32'h6666_0384;
    cyc();
    inst_data_ok_i = 1'b0;
    check_val("exr.valid", 32'(if_valid_o), 32'd0);
    do_fetch("exr.tgt", 32'hbfc0_0500, 32'h7777_0500, 1'b0, 32'h0);

    // Exception coincident with data_ok
    inst_addr_ok_i = 1'b1;
    cyc();
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = 32'h8888_0504;
    exception_i    = 1'b1;
    exception_pc_i = 32'hbfc0_0600;
    cyc();
    inst_data_ok_i = 1'b0;
    exception_i    = 1'b0;
    check_val("exd.valid", 32'(if_valid_o), 32'd0);

    // PC wrap at top of address space
    do_fetch("wrap0", 32'hbfc0_0600, 32'h9999_0600, 1'b1, 32'hffff_fffc);
    do_fetch("wrap1", 32'hffff_fffc, 32'haaaa_fffc, 1'b0, 32'h0);
    check_val("wrap.addr", inst_addr_o, 32'h0000_0000);

`ifdef FETCH_ADEL_CHECK_EN
    do_fetch("adel.br", 32'h0000_0000, 32'hbbbb_0000, 1'b1, 32'hbfc0_0102);
    check_val("adel.req",  32'(inst_req_o), 32'd0);
    check_val("adel.addr", inst_addr_o, 32'hbfc0_0102);
    cyc();
    check_val("adel.valid", 32'(if_valid_o), 32'd1);
    check_val("adel.pc",    if_pc_o, 32'hbfc0_0102);
    check_val("adel.inst",  if_inst_o, 32'd0);
    check_val("adel.excep", if_exception_type_o, 32'h8000_0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
